// File: rtl/present_key_sched_ctrl.sv
// PRESENT round-key sequencer: latches a master key and streams K1..K(NUM_ROUNDS+1)
// over a valid/ready handshake, applying one key-schedule update per accepted key.
module present_key_sched_ctrl #(
  parameter int unsigned KEY_SIZE   = 80,
  parameter int unsigned NUM_ROUNDS = 31,
  parameter int unsigned RK_WIDTH   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_SIZE-1:0] key_in,
  input  logic                abort,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [RK_WIDTH-1:0] rk_data,
  output logic [4:0]          rk_idx,
  output logic                busy,
  output logic                done
);

  if (KEY_SIZE != 80 && KEY_SIZE != 128) begin : g_bad_key_size
    $error("present_key_sched_ctrl: KEY_SIZE must be 80 or 128");
  end
  if (NUM_ROUNDS > 31 || NUM_ROUNDS < 1) begin : g_bad_num_rounds
    $error("present_key_sched_ctrl: NUM_ROUNDS must be 1..31");
  end
  if (RK_WIDTH != 64) begin : g_bad_rk_width
    $error("present_key_sched_ctrl: RK_WIDTH must be 64");
  end

  // Bit position where the round counter is folded into the rotated key.
  localparam int unsigned CtrLsb  = (KEY_SIZE == 128) ? 62 : 15;
  localparam logic [4:0]  LastIdx = 5'(NUM_ROUNDS);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [KEY_SIZE-1:0] key_q, key_d;
  logic [4:0]          idx_q, idx_d;
  logic                done_q, done_d;
  logic                xfer;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // One key-schedule step: rotate left 61, S-box the top nibble(s), fold in the counter.
  function automatic logic [KEY_SIZE-1:0] key_update(input logic [KEY_SIZE-1:0] k,
                                                     input logic [4:0]          c);
    logic [KEY_SIZE-1:0] t;
    t = (k << 61) | (k >> (KEY_SIZE - 61));
    t[KEY_SIZE-1 -: 4] = sbox(t[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == 128) begin
      t[KEY_SIZE-5 -: 4] = sbox(t[KEY_SIZE-5 -: 4]);
    end
    t[CtrLsb +: 5] = t[CtrLsb +: 5] ^ c;
    return t;
  endfunction

  assign rk_valid = (state_q == StRun);
  assign busy     = (state_q == StRun);
  assign rk_data  = key_q[KEY_SIZE-1 -: RK_WIDTH];
  assign rk_idx   = idx_q;
  assign done     = done_q;
  assign xfer     = rk_valid && rk_ready;

  // Next-state: load on start, advance on transfer, abort overrides a coincident transfer.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          key_d   = key_in;
          idx_d   = 5'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (xfer) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
            key_d = key_update(key_q, idx_q + 5'd1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, key and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      idx_q   <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_present_key_sched_ctrl.sv
// Scoreboard bench for present_key_sched_ctrl: an 80-bit and a 128-bit instance, each
// checked against a schedule model, plus a full PRESENT-80 encryption known answer.
module tb_present_key_sched_ctrl;

  typedef struct packed {
    logic [4:0]  idx;
    logic [63:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start_a = 1'b0, abort_a = 1'b0, rdy_a = 1'b0;
  logic [79:0] key_a = '0;
  logic        valid_a, busy_a, done_a;
  logic [63:0] data_a;
  logic [4:0]  idx_a;

  logic         start_b = 1'b0, abort_b = 1'b0, rdy_b = 1'b0;
  logic [127:0] key_b = '0;
  logic         valid_b, busy_b, done_b;
  logic [63:0]  data_b;
  logic [4:0]   idx_b;

  int n_checks = 0;
  int n_errors = 0;

  sb_t         q_a[$];
  sb_t         q_b[$];
  bit          exp_done [2];
  logic [63:0] rk_seen [2][32];

  present_key_sched_ctrl #(.KEY_SIZE(80), .NUM_ROUNDS(31), .RK_WIDTH(64)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .key_in(key_a), .abort(abort_a),
    .rk_valid(valid_a), .rk_ready(rdy_a), .rk_data(data_a), .rk_idx(idx_a),
    .busy(busy_a), .done(done_a)
  );

  present_key_sched_ctrl #(.KEY_SIZE(128), .NUM_ROUNDS(31), .RK_WIDTH(64)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .key_in(key_b), .abort(abort_b),
    .rk_valid(valid_b), .rk_ready(rdy_b), .rk_data(data_b), .rk_idx(idx_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sbox_ref(input logic [3:0] x);
    logic [63:0] tab;
    tab = 64'hC56B90AD3EF84712;
    return 4'(tab >> (4 * (15 - int'(x))));
  endfunction

  // Reference schedule: whole-key arithmetic on a 128-bit variable, masked to the key size.
  function automatic void push_schedule(input int w, input logic [127:0] mk);
    int unsigned  ks;
    logic [127:0] mask, k;
    logic [3:0]   nib;
    sb_t          e;
    ks   = (w == 0) ? 80 : 128;
    mask = (w == 0) ? {48'h0, {80{1'b1}}} : {128{1'b1}};
    k    = mk & mask;
    for (int r = 0; r < 32; r++) begin
      e.idx  = 5'(r);
      e.data = 64'(k >> (ks - 64));
      if (w == 0) q_a.push_back(e);
      else        q_b.push_back(e);
      k   = ((k << 61) | (k >> (ks - 61))) & mask;
      nib = 4'(k >> (ks - 4));
      k   = (k & ~(128'hF << (ks - 4))) | (128'(sbox_ref(nib)) << (ks - 4));
      if (ks == 128) begin
        nib = 4'(k >> 120);
        k   = (k & ~(128'hF << 120)) | (128'(sbox_ref(nib)) << 120);
      end
      k = k ^ (128'(r + 1) << ((ks == 80) ? 15 : 62));
    end
  endfunction

  // PRESENT-80 encryption of plaintext 0 using the round keys collected from dut_a.
  function automatic logic [63:0] encrypt_zero();
    logic [63:0] s, t, p;
    s = '0;
    for (int r = 0; r < 31; r++) begin
      s = s ^ rk_seen[0][r];
      t = '0;
      for (int n = 0; n < 16; n++) t = t | (64'(sbox_ref(4'(s >> (4 * n)))) << (4 * n));
      p = '0;
      for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (i * 16) % 63] = t[i];
      s = p;
    end
    return s ^ rk_seen[0][31];
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Per-cycle monitor for one instance: done/busy expectations, then peek or pop the queue.
  task automatic mon_step(input int w, input logic v, input logic b, input logic d,
                          input logic r, input logic a, input logic [63:0] data,
                          input logic [4:0] idx);
    sb_t e;
    int  qs;
    chk($sformatf("done[%0d]", w), 128'(d), 128'(exp_done[w]));
    exp_done[w] = 1'b0;
    chk($sformatf("busy[%0d]", w), 128'(b), 128'(v));
    if (!v) return;
    qs = (w == 0) ? q_a.size() : q_b.size();
    n_checks++;
    if (qs == 0) begin
      n_errors++;
      $display("FAIL unexpected_valid[%0d] got idx=%0d data=%h required=no key", w, idx, data);
      return;
    end
    e = (w == 0) ? q_a[0] : q_b[0];
    if (idx !== e.idx || data !== e.data) begin
      n_errors++;
      $display("FAIL rk[%0d] got idx=%0d data=%h required idx=%0d data=%h",
               w, idx, data, e.idx, e.data);
    end
    if (r && !a) begin
      if (w == 0) void'(q_a.pop_front());
      else        void'(q_b.pop_front());
      rk_seen[w][idx] = data;
      if (e.idx == 5'd31) exp_done[w] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_done[0] = 1'b0;
      exp_done[1] = 1'b0;
    end else begin
      mon_step(0, valid_a, busy_a, done_a, rdy_a, abort_a, data_a, idx_a);
      mon_step(1, valid_b, busy_b, done_b, rdy_b, abort_b, data_b, idx_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a_run(input logic [79:0] k);
    start_a = 1'b1;
    key_a   = k;
    push_schedule(0, {48'h0, k});
    tick();
    start_a = 1'b0;
  endtask

  // Drive rk_ready with the given duty until the run ends (0) or stop_idx is valid (1).
  task automatic stream_a(input int duty, input int stop_idx, output int status);
    for (int n = 0; n < 2000; n++) begin
      if (!busy_a) begin
        status = 0;
        return;
      end
      if (valid_a && int'(idx_a) == stop_idx) begin
        status = 1;
        return;
      end
      rdy_a = (int'($urandom_range(99)) < duty);
      tick();
    end
    status = 2;
    n_checks++;
    n_errors++;
    $display("FAIL stream_a_timeout got busy=%0b required=run to finish", busy_a);
  endtask

  task automatic run_b(input logic [127:0] k, input int duty);
    start_b = 1'b1;
    key_b   = k;
    push_schedule(1, k);
    tick();
    start_b = 1'b0;
    for (int n = 0; n < 2000 && busy_b; n++) begin
      rdy_b = (int'($urandom_range(99)) < duty);
      tick();
    end
    chk("run_b_finished", 128'(busy_b), 128'(0));
    chk("q_b_drained", 128'(q_b.size()), 128'(0));
  endtask

  int st;

  initial begin
    #2;
    chk("rst_valid", 128'(valid_a), 128'(0));
    chk("rst_busy", 128'(busy_a), 128'(0));
    chk("rst_done", 128'(done_a), 128'(0));
    chk("rst_data", 128'(data_a), 128'(0));
    chk("rst_idx", 128'(idx_a), 128'(0));
    chk("rst_data_b", 128'(data_b), 128'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Zero key, no backpressure: known round keys and ciphertext.
    start_a_run('0);
    stream_a(100, 99, st);
    chk("q_a_drained_zero", 128'(q_a.size()), 128'(0));
    chk("k1_zero", 128'(rk_seen[0][0]), 128'(0));
    chk("k2_zero", 128'(rk_seen[0][1]), 128'(64'hC000000000000000));
    chk("k3_zero", 128'(rk_seen[0][2]), 128'(64'h5000180000000001));
    chk("cipher_zero", 128'(encrypt_zero()), 128'(64'h5579C1387B228445));
    tick();

    // Same key under 30% ready: identical sequence, so the ciphertext must match again.
    for (int i = 0; i < 32; i++) rk_seen[0][i] = '0;
    start_a_run('0);
    stream_a(30, 99, st);
    chk("q_a_drained_stall", 128'(q_a.size()), 128'(0));
    chk("cipher_stall", 128'(encrypt_zero()), 128'(64'h5579C1387B228445));
    chk("done_pulse", 128'(done_a), 128'(1));

    // Start while done is high, then a spurious start mid-run at idx 5.
    start_a_run(80'({$urandom(), $urandom(), $urandom()}));
    chk("k1_after_done_valid", 128'(valid_a), 128'(1));
    chk("k1_after_done_idx", 128'(idx_a), 128'(0));
    stream_a(100, 5, st);
    chk("reach_idx5", 128'(st), 128'(1));
    rdy_a   = 1'b1;
    start_a = 1'b1;
    key_a   = 80'({$urandom(), $urandom(), $urandom()});
    tick();
    start_a = 1'b0;
    stream_a(70, 99, st);
    chk("q_a_drained_start_ignored", 128'(q_a.size()), 128'(0));
    tick();

    // Abort at idx 10 with ready high, then restart with all-ones key.
    start_a_run(80'({$urandom(), $urandom(), $urandom()}));
    stream_a(100, 10, st);
    chk("reach_idx10", 128'(st), 128'(1));
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("abort_valid", 128'(valid_a), 128'(0));
    chk("abort_busy", 128'(busy_a), 128'(0));
    chk("abort_done", 128'(done_a), 128'(0));
    q_a.delete();
    tick();
    start_a_run({80{1'b1}});
    stream_a(60, 99, st);
    chk("k1_ones", 128'(rk_seen[0][0]), 128'(64'hFFFFFFFFFFFFFFFF));
    chk("q_a_drained_ones", 128'(q_a.size()), 128'(0));
    tick();

    // start and abort together in IDLE: stay idle.
    start_a = 1'b1;
    abort_a = 1'b1;
    key_a   = 80'({$urandom(), $urandom(), $urandom()});
    tick();
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("start_abort_busy", 128'(busy_a), 128'(0));
    tick();
    chk("start_abort_valid", 128'(valid_a), 128'(0));

    // Asynchronous reset at idx 17, asserted and released between edges.
    start_a_run(80'({$urandom(), $urandom(), $urandom()}));
    stream_a(100, 17, st);
    chk("reach_idx17", 128'(st), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 128'(valid_a), 128'(0));
    chk("midrst_busy", 128'(busy_a), 128'(0));
    chk("midrst_data", 128'(data_a), 128'(0));
    chk("midrst_idx", 128'(idx_a), 128'(0));
    chk("midrst_done", 128'(done_a), 128'(0));
    q_a.delete();
    #3 rst = 1'b0;
    tick();
    chk("post_rst_idle", 128'(busy_a), 128'(0));
    start_a_run(80'({$urandom(), $urandom(), $urandom()}));
    chk("post_rst_idx", 128'(idx_a), 128'(0));
    stream_a(50, 99, st);
    chk("q_a_drained_post_rst", 128'(q_a.size()), 128'(0));

    // 128-bit instance: zero key known answers, then a random key with backpressure.
    run_b('0, 100);
    chk("k1_128", 128'(rk_seen[1][0]), 128'(0));
    chk("k2_128", 128'(rk_seen[1][1]), 128'(64'hCC00000000000000));
    tick();
    run_b({$urandom(), $urandom(), $urandom(), $urandom()}, 40);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
